// File: rtl/e203_dtcm_ecc_pkg.sv
// E203 DTCM SECDED shared definitions:
// FSM states and extended-Hamming code helpers.
package e203_dtcm_ecc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RMW  = 2'd1,
    WB   = 2'd2
  } ecc_state_e;

  localparam int HAM_MAX_DW  = 64;
  localparam int HAM_MAX_POS = 128;

  function automatic int ecc_cw(input int dw);
    return (dw > 32) ? 8 : 7;
  endfunction

  // Codeword position of data bit i; power-of-two slots hold check bits
  function automatic int ham_pos(input int i);
    int k;
    int r;
    k = 0;
    r = 0;
    for (int p = 3; p < HAM_MAX_POS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k == i) r = p;
        k++;
      end
    end
    return r;
  endfunction

  function automatic logic [HAM_MAX_DW-1:0] ham_mask(
    input int dw,
    input int j
  );
    logic [HAM_MAX_DW-1:0] m;
    int p;
    m = '0;
    for (int i = 0; i < HAM_MAX_DW; i++) begin
      p = ham_pos(i);
      if (i < dw) m[i] = p[j];
    end
    return m;
  endfunction

endpackage

// File: rtl/e203_secded_codec.sv
// Combinational SECDED encoder and decoder
// (Hamming check bits plus overall parity in the MSB).
module e203_secded_codec
  import e203_dtcm_ecc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0]         enc_data,
  output logic [ecc_cw(DW)-1:0] enc_chk,
  input  logic [DW-1:0]         dec_data,
  input  logic [ecc_cw(DW)-1:0] dec_chk,
  output logic [DW-1:0]         dec_out,
  output logic                  dec_corr,
  output logic                  dec_uncorr
);

  localparam int CW = ecc_cw(DW);
  localparam int HW = CW - 1;

  logic [HW-1:0] enc_h;
  logic [HW-1:0] syn;
  logic [DW-1:0] hit;
  logic          odd;
  logic          pow2;
  logic          known;

  for (genvar j = 0; j < HW; j++) begin : g_chk
    localparam logic [HAM_MAX_DW-1:0] MF = ham_mask(DW, j);
    localparam logic [DW-1:0] M = MF[DW-1:0];
    assign enc_h[j] = ^(enc_data & M);
    assign syn[j]   = dec_chk[j] ^ (^(dec_data & M));
  end

  assign enc_chk = {^{enc_data, enc_h}, enc_h};

  for (genvar i = 0; i < DW; i++) begin : g_hit
    localparam int P = ham_pos(i);
    localparam logic [HW-1:0] PS = P[HW-1:0];
    assign hit[i] = (syn == PS);
  end

  // Zero or power-of-two syndrome with odd parity is a check-bit flip
  assign odd   = ^{dec_data, dec_chk};
  assign pow2  = (syn & (syn - HW'(1))) == '0;
  assign known = pow2 | (|hit);

  assign dec_corr   = odd & known;
  assign dec_uncorr = (~odd & (|syn)) | (odd & ~known);
  assign dec_out    = dec_data ^ (hit & {DW{odd}});

endmodule

// File: rtl/e203_dtcm_ecc_ram.sv
// SECDED-protected DTCM store with read-modify-write
// for byte-masked writes and optional corrected write-back.
module e203_dtcm_ecc_ram
  import e203_dtcm_ecc_pkg::*;
#(
  parameter int DP      = 65536,
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MW      = DW / 8,
  parameter int CORR_WB = 1,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cs,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [MW-1:0]   wem,
  input  logic [DW-1:0]   din,
  input  logic [1:0]      err_inj,
  input  logic            cnt_clr,
  output logic            ready,
  output logic            rsp_valid,
  output logic [DW-1:0]   dout,
  output logic            err_corr,
  output logic            err_uncorr,
  output logic [AW-1:0]   err_addr,
  output logic [CNTW-1:0] corr_cnt
);

  localparam int CW = ecc_cw(DW);
  localparam int EW = DW + CW;

  logic [EW-1:0]   mem [DP];
  logic [EW-1:0]   rd_q;
  ecc_state_e      state_q;
  ecc_state_e      state_n;
  ecc_state_e      state;
  logic            rd_pend;
  logic [AW-1:0]   p_addr;
  logic [DW-1:0]   p_din;
  logic [MW-1:0]   p_wem;
  logic [1:0]      p_inj;
  logic [DW-1:0]   dout_q;
  logic [AW-1:0]   eaddr_q;
  logic [CNTW-1:0] cnt_q;

  logic            acc;
  logic            acc_rd;
  logic            acc_full;
  logic            acc_part;
  logic            chk_live;
  logic [DW-1:0]   dec_data;
  logic            dec_corr;
  logic            dec_uncorr;
  logic [DW-1:0]   merged;
  logic [DW-1:0]   enc_src;
  logic [CW-1:0]   enc_chk;
  logic [1:0]      wr_inj;
  logic [AW-1:0]   wr_addr;
  logic            wr_en;
  logic [EW-1:0]   wr_word;

  assign acc      = cs & ready & ~rst;
  assign acc_rd   = acc & ~we;
  assign acc_full = acc & we & (&wem);
  assign acc_part = acc & we & (|wem) & ~(&wem);
  assign chk_live = rd_pend | (state_q == RMW);

  e203_secded_codec #(
    .DW(DW)
  ) u_codec (
    .enc_data  (enc_src),
    .enc_chk   (enc_chk),
    .dec_data  (rd_q[DW-1:0]),
    .dec_chk   (rd_q[EW-1:DW]),
    .dec_out   (dec_data),
    .dec_corr  (dec_corr),
    .dec_uncorr(dec_uncorr)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // WB is entered in the response cycle itself, so it is never registered
  always_comb begin
    state = state_q;
    if (state_q == IDLE && rd_pend && dec_corr && CORR_WB != 0)
      state = WB;
    state_n = IDLE;
    unique case (1'b1)
      (state == IDLE): state_n = acc_part ? RMW : IDLE;
      default:         state_n = IDLE;
    endcase
  end

  always_comb begin
    ready      = (state == IDLE);
    rsp_valid  = rd_pend;
    dout       = rd_pend ? dec_data : dout_q;
    err_corr   = chk_live & dec_corr;
    err_uncorr = chk_live & dec_uncorr;
    err_addr   = (err_corr | err_uncorr) ? p_addr : eaddr_q;
    corr_cnt   = cnt_q;
    merged     = dec_data;
    for (int b = 0; b < MW; b++)
      if (p_wem[b]) merged[8*b +: 8] = p_din[8*b +: 8];
    enc_src = din;
    wr_addr = addr;
    wr_inj  = err_inj;
    wr_en   = acc_full;
    unique case (1'b1)
      (state == RMW): begin
        enc_src = merged;
        wr_addr = p_addr;
        wr_inj  = p_inj;
        wr_en   = ~dec_uncorr;
      end
      (state == WB): begin
        enc_src = dec_data;
        wr_addr = p_addr;
        wr_inj  = 2'b00;
        wr_en   = 1'b1;
      end
      default: ;
    endcase
    wr_en   = wr_en & ~rst;
    wr_word = {enc_chk, enc_src ^ {{(DW-2){1'b0}}, wr_inj}};
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
    if (acc_rd | acc_part) rd_q <= mem[addr];
    if (acc) begin
      p_addr <= addr;
      p_din  <= din;
      p_wem  <= wem;
      p_inj  <= err_inj;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      dout_q  <= '0;
      eaddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      rd_pend <= acc_rd;
      if (rd_pend) dout_q <= dec_data;
      if (err_corr | err_uncorr) eaddr_q <= p_addr;
      if (cnt_clr)
        cnt_q <= '0;
      else if (err_corr && cnt_q != '1)
        cnt_q <= cnt_q + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_e203_dtcm_ecc_ram.sv
// Self-checking bench for e203_dtcm_ecc_ram with
// directed scenarios and a randomized word/flip model.
module tb_e203_dtcm_ecc_ram;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int CNTW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b0;
  logic we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [MW-1:0] wem = '0;
  logic [DW-1:0] din = '0;
  logic [1:0] err_inj = 2'b00;
  logic cnt_clr = 1'b0;
  logic ready;
  logic rsp_valid;
  logic [DW-1:0] dout;
  logic err_corr;
  logic err_uncorr;
  logic [AW-1:0] err_addr;
  logic [CNTW-1:0] corr_cnt;

  int vec = 0;
  int miss = 0;

  e203_dtcm_ecc_ram #(
    .DP(64), .AW(AW), .DW(DW), .MW(MW),
    .CORR_WB(1), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we),
    .addr(addr), .wem(wem), .din(din),
    .err_inj(err_inj), .cnt_clr(cnt_clr),
    .ready(ready), .rsp_valid(rsp_valid),
    .dout(dout), .err_corr(err_corr),
    .err_uncorr(err_uncorr), .err_addr(err_addr),
    .corr_cnt(corr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input logic w,
    input logic [AW-1:0] a,
    input logic [MW-1:0] m,
    input logic [DW-1:0] d,
    input logic [1:0] inj
  );
    int n;
    n = 0;
    cs = 1'b1; we = w; addr = a;
    wem = m; din = d; err_inj = inj;
    while (!ready && n < 8) begin
      tick();
      n++;
    end
    if (!ready) begin
      vec++; miss++;
      $display("FAIL issue_timeout: ready=%b after %0d cycles", ready, n);
    end
    tick();
    cs = 1'b0; we = 1'b0; wem = '0;
    din = '0; err_inj = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    vec++; if (ready !== 1'b1) begin miss++; $display("FAIL rst_ready: got %b exp 1", ready); end
    vec++; if (rsp_valid !== 1'b0) begin miss++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
    vec++; if (dout !== 32'h0) begin miss++; $display("FAIL rst_dout: got %h exp 0", dout); end
    vec++; if (err_corr !== 1'b0) begin miss++; $display("FAIL rst_err_corr: got %b exp 0", err_corr); end
    vec++; if (err_uncorr !== 1'b0) begin miss++; $display("FAIL rst_err_uncorr: got %b exp 0", err_uncorr); end
    vec++; if (err_addr !== '0) begin miss++; $display("FAIL rst_err_addr: got %0d exp 0", err_addr); end
    vec++; if (corr_cnt !== '0) begin miss++; $display("FAIL rst_corr_cnt: got %0d exp 0", corr_cnt); end
  endtask

  task automatic test_full_write();
    issue(1'b1, 6'd5, 4'hF, 32'hDEADBEEF, 2'b00);
    issue(1'b0, 6'd5, 4'h0, 32'h0, 2'b00);
    vec++; if (rsp_valid !== 1'b1) begin miss++; $display("FAIL fw_rsp_valid: got %b exp 1", rsp_valid); end
    vec++; if (dout !== 32'hDEADBEEF) begin miss++; $display("FAIL fw_dout: got %h exp deadbeef", dout); end
    vec++; if ({err_corr, err_uncorr} !== 2'b00) begin miss++; $display("FAIL fw_flags: got %b%b exp 00", err_corr, err_uncorr); end
    vec++; if (ready !== 1'b1) begin miss++; $display("FAIL fw_ready: got %b exp 1", ready); end
    tick();
    vec++; if (dout !== 32'hDEADBEEF) begin miss++; $display("FAIL fw_dout_hold: got %h exp deadbeef", dout); end
  endtask

  task automatic test_partial_corr();
    issue(1'b1, 6'd7, 4'hF, 32'h11223344, 2'b01);
    issue(1'b1, 6'd7, 4'b0010, 32'h0000AA00, 2'b00);
    vec++; if (ready !== 1'b0) begin miss++; $display("FAIL pc_ready_low: got %b exp 0", ready); end
    vec++; if (err_corr !== 1'b1) begin miss++; $display("FAIL pc_err_corr: got %b exp 1", err_corr); end
    vec++; if (err_addr !== 6'd7) begin miss++; $display("FAIL pc_err_addr: got %0d exp 7", err_addr); end
    tick();
    vec++; if (ready !== 1'b1) begin miss++; $display("FAIL pc_ready_back: got %b exp 1", ready); end
    vec++; if (corr_cnt !== 2'd1) begin miss++; $display("FAIL pc_cnt: got %0d exp 1", corr_cnt); end
    issue(1'b0, 6'd7, 4'h0, 32'h0, 2'b00);
    vec++; if (dout !== 32'h1122AA44) begin miss++; $display("FAIL pc_dout: got %h exp 1122aa44", dout); end
    vec++; if ({err_corr, err_uncorr} !== 2'b00) begin miss++; $display("FAIL pc_rd_flags: got %b%b exp 00", err_corr, err_uncorr); end
    tick();
  endtask

  task automatic test_read_wb();
    issue(1'b1, 6'd9, 4'hF, 32'h0, 2'b01);
    issue(1'b0, 6'd9, 4'h0, 32'h0, 2'b00);
    vec++; if (dout !== 32'h0) begin miss++; $display("FAIL wb_dout: got %h exp 0", dout); end
    vec++; if (err_corr !== 1'b1) begin miss++; $display("FAIL wb_err_corr: got %b exp 1", err_corr); end
    vec++; if (err_addr !== 6'd9) begin miss++; $display("FAIL wb_err_addr: got %0d exp 9", err_addr); end
    vec++; if (ready !== 1'b0) begin miss++; $display("FAIL wb_ready_low: got %b exp 0", ready); end
    tick();
    vec++; if (ready !== 1'b1) begin miss++; $display("FAIL wb_ready_back: got %b exp 1", ready); end
    issue(1'b0, 6'd9, 4'h0, 32'h0, 2'b00);
    vec++; if (err_corr !== 1'b0) begin miss++; $display("FAIL wb_second_corr: got %b exp 0", err_corr); end
    vec++; if (dout !== 32'h0) begin miss++; $display("FAIL wb_second_dout: got %h exp 0", dout); end
    vec++; if (corr_cnt !== 2'd2) begin miss++; $display("FAIL wb_cnt: got %0d exp 2", corr_cnt); end
    tick();
  endtask

  task automatic test_uncorr();
    issue(1'b1, 6'd3, 4'hF, 32'hA5A5A5A5, 2'b11);
    issue(1'b1, 6'd3, 4'b0001, 32'h000000FF, 2'b00);
    vec++; if (err_uncorr !== 1'b1) begin miss++; $display("FAIL uc_rmw_uncorr: got %b exp 1", err_uncorr); end
    vec++; if (err_corr !== 1'b0) begin miss++; $display("FAIL uc_rmw_corr: got %b exp 0", err_corr); end
    vec++; if (err_addr !== 6'd3) begin miss++; $display("FAIL uc_err_addr: got %0d exp 3", err_addr); end
    tick();
    issue(1'b0, 6'd3, 4'h0, 32'h0, 2'b00);
    vec++; if (err_uncorr !== 1'b1) begin miss++; $display("FAIL uc_rd_uncorr: got %b exp 1", err_uncorr); end
    vec++; if (dout !== 32'hA5A5A5A6) begin miss++; $display("FAIL uc_rd_dout: got %h exp a5a5a5a6", dout); end
    tick();
  endtask

  task automatic test_cnt_sat();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      issue(1'b1, 6'd10, 4'hF, 32'h55, 2'b01);
      issue(1'b0, 6'd10, 4'h0, 32'h0, 2'b00);
      vec++; if (err_corr !== 1'b1) begin miss++; $display("FAIL sat_corr%0d: got %b exp 1", k, err_corr); end
      tick();
    end
    vec++; if (corr_cnt !== 2'd3) begin miss++; $display("FAIL sat_cnt: got %0d exp 3", corr_cnt); end
    issue(1'b1, 6'd10, 4'hF, 32'h55, 2'b01);
    issue(1'b0, 6'd10, 4'h0, 32'h0, 2'b00);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    vec++; if (corr_cnt !== 2'd0) begin miss++; $display("FAIL sat_clr: got %0d exp 0", corr_cnt); end
  endtask

  task automatic test_reset_rmw();
    issue(1'b1, 6'd4, 4'hF, 32'hFFFFFFFF, 2'b00);
    issue(1'b1, 6'd4, 4'b0001, 32'h0, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++; if (ready !== 1'b1) begin miss++; $display("FAIL rr_ready: got %b exp 1", ready); end
    vec++; if (rsp_valid !== 1'b0) begin miss++; $display("FAIL rr_rsp_valid: got %b exp 0", rsp_valid); end
    vec++; if (dout !== 32'h0) begin miss++; $display("FAIL rr_dout: got %h exp 0", dout); end
    vec++; if (err_addr !== '0) begin miss++; $display("FAIL rr_err_addr: got %0d exp 0", err_addr); end
    vec++; if (corr_cnt !== '0) begin miss++; $display("FAIL rr_cnt: got %0d exp 0", corr_cnt); end
    issue(1'b0, 6'd4, 4'h0, 32'h0, 2'b00);
    vec++; if (dout !== 32'hFFFFFFFF) begin miss++; $display("FAIL rr_dout_kept: got %h exp ffffffff", dout); end
    tick();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 6'd20, 4'hF, 32'h12345678, 2'b00);
    issue(1'b1, 6'd20, 4'b1100, 32'hABCD0000, 2'b00);
    vec++; if (ready !== 1'b0) begin miss++; $display("FAIL b2b_ready: got %b exp 0", ready); end
    issue(1'b0, 6'd20, 4'h0, 32'h0, 2'b00);
    vec++; if (rsp_valid !== 1'b1) begin miss++; $display("FAIL b2b_rsp_valid: got %b exp 1", rsp_valid); end
    vec++; if (dout !== 32'hABCD5678) begin miss++; $display("FAIL b2b_dout: got %h exp abcd5678", dout); end
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] md [16];
    logic [1:0] mf [16];
    logic [AW-1:0] merr;
    int mcnt;
    int idx;
    int kind;
    int nf;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] bm;
    logic [DW-1:0] exp_d;
    logic [MW-1:0] m;
    logic [1:0] inj;
    logic ec;
    logic eu;
    merr = '0;
    mcnt = 0;
    for (int i = 0; i < 16; i++) begin
      md[i] = $urandom;
      mf[i] = 2'b00;
      issue(1'b1, AW'(32 + i), 4'hF, md[i], 2'b00);
    end
    for (int n = 0; n < 300; n++) begin
      idx = $urandom_range(0, 15);
      a = AW'(32 + idx);
      kind = $urandom_range(0, 2);
      d = $urandom;
      inj = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      nf = int'(mf[idx][0]) + int'(mf[idx][1]);
      ec = 1'b0;
      eu = 1'b0;
      if (kind == 0) begin
        issue(1'b1, a, 4'hF, d, inj);
        md[idx] = d;
        mf[idx] = inj;
        vec++; if ({rsp_valid, err_corr, err_uncorr} !== 3'b000) begin miss++; $display("FAIL rnd_fw_%0d: flags %b%b%b exp 000", n, rsp_valid, err_corr, err_uncorr); end
      end else if (kind == 1) begin
        m = 4'($urandom_range(1, 14));
        issue(1'b1, a, m, d, inj);
        ec = (nf == 1);
        eu = (nf == 2);
        vec++; if ({err_corr, err_uncorr} !== {ec, eu}) begin miss++; $display("FAIL rnd_pw_%0d: flags %b%b exp %b%b", n, err_corr, err_uncorr, ec, eu); end
        if (!eu) begin
          for (int b = 0; b < MW; b++) bm[8*b +: 8] = {8{m[b]}};
          md[idx] = (md[idx] & ~bm) | (d & bm);
          mf[idx] = inj;
        end
      end else begin
        issue(1'b0, a, 4'h0, 32'h0, 2'b00);
        ec = (nf == 1);
        eu = (nf == 2);
        exp_d = eu ? (md[idx] ^ {30'b0, mf[idx]}) : md[idx];
        vec++; if (rsp_valid !== 1'b1) begin miss++; $display("FAIL rnd_rv_%0d: got %b exp 1", n, rsp_valid); end
        vec++; if (dout !== exp_d) begin miss++; $display("FAIL rnd_rd_%0d: addr %0d got %h exp %h", n, a, dout, exp_d); end
        vec++; if ({err_corr, err_uncorr} !== {ec, eu}) begin miss++; $display("FAIL rnd_rf_%0d: flags %b%b exp %b%b", n, err_corr, err_uncorr, ec, eu); end
        if (ec) mf[idx] = 2'b00;
      end
      if (ec || eu) merr = a;
      if (ec && mcnt < 3) mcnt++;
      vec++; if (err_addr !== merr) begin miss++; $display("FAIL rnd_ea_%0d: got %0d exp %0d", n, err_addr, merr); end
      tick();
      vec++; if (corr_cnt !== 2'(mcnt)) begin miss++; $display("FAIL rnd_cnt_%0d: got %0d exp %0d", n, corr_cnt, mcnt); end
      vec++; if (ready !== 1'b1) begin miss++; $display("FAIL rnd_rdy_%0d: got %b exp 1", n, ready); end
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_partial_corr();
    test_read_wb();
    test_uncorr();
    test_cnt_sat();
    test_reset_rmw();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/e203_dtcm_ecc_ram.md
# e203_dtcm_ecc_ram

SECDED-protected, parametrised DTCM data store for the E203 core. It stores DW data bits plus CW check bits per word and corrects single-bit errors on every read. Partial (byte-masked) writes use an internal read-modify-write sequence, and corrected words can optionally be written back. It sits between the DTCM controller and the physical array, and adds a ready handshake plus error reporting.

## Interface
Parameters:
- DP, 65536: depth in words.
- AW, 16: address width; DP ≤ 2^AW.
- DW, 32: data width; legal values are 32 and 64.
- MW, DW/8: byte-mask width.
- CW, derived: check bits; 7 for DW=32, 8 for DW=64.
- CORR_WB, 1: when 1, a read with a corrected error writes the corrected word back.
- CNTW, 16: width of the corrected-error counter.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- cs, in, 1: request valid.
- we, in, 1: 1 = write, 0 = read.
- addr, in, AW: word address.
- wem, in, MW: byte write enable.
- din, in, DW: write data.
- err_inj, in, 2: inject errors on the encoded write; bit0 flips stored data bit 0, bit1 flips stored data bit 1.
- cnt_clr, in, 1: clear the corrected-error counter.
- ready, out, 1: request accepted when cs & ready.
- rsp_valid, out, 1: read data valid.
- dout, out, DW: corrected read data.
- err_corr, out, 1: single-bit error corrected (one-cycle pulse).
- err_uncorr, out, 1: double-bit error detected (one-cycle pulse).
- err_addr, out, AW: address of the most recent error event.
- corr_cnt, out, CNTW: saturating count of corrected errors.

## Operation
- **Accept.** A request is accepted on a cycle with cs & ready. The requester holds cs, we, addr, wem and din until accepted. cs while ready=0 has no effect.
- **States:**
  - IDLE: ready=1.
  - RMW: a partial write is being completed.
  - WB: a corrected word is being written back.
- **Full write** (we=1, wem all ones): encode din, XOR err_inj into data bits 0 and 1, and write array[addr]. Stay in IDLE. No response.
- **Partial write** (we=1, wem not all ones and nonzero):
  - Accept cycle: read array[addr]; go to RMW.
  - RMW cycle: decode the old word. Merge the corrected old bytes with din under wem, re-encode (err_inj applied), write, and return to IDLE.
  - If decode is uncorrectable: the write is abandoned, the location is unchanged, and err_uncorr is pulsed.
  - If decode is corrected: err_corr is pulsed and the counter increments.
- **wem = 0 with we=1:** accepted as a no-op, stays in IDLE.
- **Read** (we=0): read array[addr].
  - Next cycle: rsp_valid=1, dout = corrected data.
  - Clean word: stay in IDLE.
  - Corrected word: err_corr=1. If CORR_WB=1, that cycle is state WB and the corrected word is re-encoded (err_inj not applied) and written, then back to IDLE. If CORR_WB=0, stay in IDLE.
  - Uncorrectable word: err_uncorr=1 and dout = raw stored data bits. No write-back.
- **Check-bit-only errors:** reported as corrected. dout is unaffected.
- **err_addr:** loaded with the address of the word on every err_corr or err_uncorr pulse; otherwise held.
- **corr_cnt:** +1 per err_corr pulse, saturating at 2^CNTW−1. cnt_clr clears it to 0; if cnt_clr coincides with an increment, the result is 0.
- **Array contents:** not reset. Software initialises words with full writes; reading an uninitialised word may report uncorrectable.

## Timing
- **Reset values:** ready=1, state=IDLE, rsp_valid=0, dout=0, err_corr=0, err_uncorr=0, err_addr=0, corr_cnt=0.
- **Read latency:** 1 cycle. Accept at T gives rsp_valid, dout and error flags at T+1. dout is held until the next read response.
- **ready:** low exactly one cycle after a partial-write accept, or after a corrected read when CORR_WB=1. Throughput is 1 request/cycle otherwise.
- **Back-to-back ordering:** a read of the same address immediately after a partial write (accepted at T+2, response at T+3) returns the merged data.
- **Reset mid-RMW or mid-WB:** the pending write is dropped and the block returns to IDLE with ready=1 the next cycle.

## Structure
- Package e203_dtcm_ecc_pkg holds:
  - state encodings: IDLE=2'd0, RMW=2'd1, WB=2'd2;
  - function ecc_cw(DW);
  - Hamming-plus-overall-parity check-matrix constants.
- One combinational sub-module, e203_secded_codec (parameter DW). It provides the encoder, plus a decoder producing data, corr and uncorr.
- The top level holds the array (registered read), the FSM, the merge logic, the error registers and the counter.

## Test plan
- **Full write, then read.** Write 0xDEADBEEF to addr 5, read addr 5 → rsp_valid at T+1, dout=0xDEADBEEF, no error flags.
- **Partial write with single-bit error.** Write 0x11223344 to addr 7 with err_inj=2'b01, then partial write wem=4'b0010, din=0x0000AA00 → ready low for 1 cycle, err_corr pulses, corr_cnt=1. A following read returns 0x1122AA44 with no error.
- **Read with write-back.** Inject a single-bit error at addr 9 (stored 0x0), read it with CORR_WB=1 → dout=0x0, err_corr=1, err_addr=9, ready low 1 cycle. A second read shows no error and corr_cnt=2.
- **Uncorrectable partial write.** Inject a double-bit error (err_inj=2'b11) at addr 3, then partial write → err_uncorr pulses and the stored word is unchanged. A subsequent read again flags err_uncorr.
- **Counter saturation and clear.** With CNTW=2, trigger 5 corrected reads → corr_cnt=3. Assert cnt_clr together with a corrected read → corr_cnt=0.
- **Reset during RMW.** Assert rst in the RMW cycle of a partial write to addr 4 (old value 0xFFFFFFFF) → all outputs return to reset values, ready=1 the next cycle, and a read of addr 4 returns 0xFFFFFFFF.
